// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for the shared data-memory port (req0 = CPU load/store, req1 = secondary loader).
// Latency: write done at k+2, read done at k+2+RD_LATENCY; requests are only sampled in IDLE, so losers simply hold req.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             gnt0,
    output logic             done0,
    output logic [WIDTH-1:0] rdata0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt1,
    output logic             done1,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_ena,
    output logic             mem_wr_ena,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state_q;
    logic             ptr_q;
    logic             win_q;
    logic             we_q;
    logic [2:0]       cnt_q;
    logic             gnt0_q, gnt1_q, done0_q, done1_q;
    logic             mem_ena_q, mem_wr_ena_q, busy_q;
    logic [WIDTH-1:0] mem_addr_q, mem_wdata_q;
    logic [WIDTH-1:0] rdata0_q, rdata1_q;
    logic             pick1_d;

    // Requester 1 wins when alone, or when both ask and the pointer favours it.
    assign pick1_d = req1 & (~req0 | ptr_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            mem_ena_q    <= 1'b0;
            mem_wr_ena_q <= 1'b0;
            busy_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        win_q        <= pick1_d;
                        we_q         <= pick1_d ? we1 : we0;
                        mem_ena_q    <= 1'b1;
                        mem_wr_ena_q <= pick1_d ? we1 : we0;
                        mem_addr_q   <= pick1_d ? addr1 : addr0;
                        mem_wdata_q  <= pick1_d ? wdata1 : wdata0;
                        gnt0_q       <= ~pick1_d;
                        gnt1_q       <= pick1_d;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_ena_q    <= 1'b0;
                    mem_wr_ena_q <= 1'b0;
                    if (we_q) begin
                        done0_q     <= ~win_q;
                        done1_q     <= win_q;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        state_q     <= DONE;
                    end else begin
                        cnt_q   <= 3'(RD_LATENCY);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // The final WAIT edge is the read-data capture edge.
                    if (cnt_q == 3'd1) begin
                        if (win_q) rdata1_q <= mem_rdata;
                        else       rdata0_q <= mem_rdata;
                        done0_q     <= ~win_q;
                        done1_q     <= win_q;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    ptr_q   <= ~win_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_ena    = mem_ena_q;
    assign mem_wr_ena = mem_wr_ena_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus contention, abort and withdrawn-request sequences.
module tb_mem_port_arbiter;
    localparam int W = 32;
    localparam int L = 2;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [W-1:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic         gnt0, done0, gnt1, done1, mem_ena, mem_wr_ena, busy;
    logic [W-1:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_rd [2];
    logic [W-1:0] mem [64];
    logic [W-1:0] mem_rd_q;

    typedef struct {
        int           rq;
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] exp_rd;
    } vec_t;
    vec_t vecs [8];

    mem_port_arbiter #(.WIDTH(W), .RD_LATENCY(L)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ena(mem_ena),
        .mem_wr_ena(mem_wr_ena), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    // Simple word-addressed memory; read data stays put until the next read.
    always @(posedge clock) begin
        if (mem_ena) begin
            if (mem_wr_ena) mem[mem_addr[7:2]] <= mem_wdata;
            else            mem_rd_q <= mem[mem_addr[7:2]];
        end
    end
    assign mem_rdata = mem_rd_q;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic g0, input logic g1, input logic d0,
                            input logic d1, input logic ena, input logic wr,
                            input logic [W-1:0] a, input logic [W-1:0] wd, input logic b);
        chk({tag, ".gnt0"}, W'(gnt0), W'(g0));
        chk({tag, ".gnt1"}, W'(gnt1), W'(g1));
        chk({tag, ".done0"}, W'(done0), W'(d0));
        chk({tag, ".done1"}, W'(done1), W'(d1));
        chk({tag, ".mem_ena"}, W'(mem_ena), W'(ena));
        chk({tag, ".mem_wr_ena"}, W'(mem_wr_ena), W'(wr));
        chk({tag, ".mem_addr"}, mem_addr, a);
        chk({tag, ".mem_wdata"}, mem_wdata, wd);
        chk({tag, ".busy"}, W'(busy), W'(b));
        chk({tag, ".rdata0"}, rdata0, exp_rd[0]);
        chk({tag, ".rdata1"}, rdata1, exp_rd[1]);
    endtask

    task automatic set_req(input int rq, input logic v, input logic we,
                           input logic [W-1:0] a, input logic [W-1:0] wd);
        if (rq == 0) begin req0 = v; we0 = we; addr0 = a; wdata0 = wd; end
        else         begin req1 = v; we1 = we; addr1 = a; wdata1 = wd; end
    endtask

    // Caller is at a negedge with the FSM in IDLE.
    task automatic do_access(input string tag, input vec_t v);
        set_req(v.rq, 1'b1, v.we, v.addr, v.wdata);
        @(negedge clock);
        chk_outs({tag, ".issue"}, v.rq == 0, v.rq == 1, 1'b0, 1'b0, 1'b1, v.we, v.addr, v.wdata, 1'b1);
        set_req(v.rq, 1'b0, 1'b0, '0, '0);
        if (!v.we) begin
            for (int i = 0; i < L; i++) begin
                @(negedge clock);
                chk_outs({tag, ".wait"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v.addr, v.wdata, 1'b1);
            end
        end
        @(negedge clock);
        if (!v.we) exp_rd[v.rq] = v.exp_rd;
        chk_outs({tag, ".done"}, 1'b0, 1'b0, v.rq == 0, v.rq == 1, 1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clock);
        chk_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        int   ngnt;
        int   ndone1;
        int   nbad0;
        logic exp_next1;
        logic pending;
        vec_t v;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[8]   = 32'h1234_5678;
        mem_rd_q = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        vecs[0] = '{0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1, 1'b0, 32'h20, 32'h0, 32'h1234_5678};
        vecs[2] = '{1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF};
        vecs[3] = '{0, 1'b0, 32'h20, 32'h0, 32'h1234_5678};
        vecs[4] = '{1, 1'b1, 32'h24, 32'hCAFE_F00D, 32'h0};
        vecs[5] = '{0, 1'b0, 32'h24, 32'h0, 32'hCAFE_F00D};
        vecs[6] = '{0, 1'b1, 32'h10, 32'h0000_0001, 32'h0};
        vecs[7] = '{1, 1'b0, 32'h10, 32'h0, 32'h0000_0001};

        // Reset and idle.
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk_outs("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk_outs("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        end

        for (int i = 0; i < 8; i++) do_access($sformatf("vec%0d", i), vecs[i]);

        // Contention from reset: both requesters keep asking.
        reset_n = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        @(negedge clock);
        reset_n = 1'b1;
        set_req(0, 1'b1, 1'b1, 32'h30, 32'hAAAA_0000);
        set_req(1, 1'b1, 1'b1, 32'h34, 32'hBBBB_1111);
        ngnt = 0;
        exp_next1 = 1'b0;
        pending = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            chk("cont.both_gnt", W'(gnt0 & gnt1), '0);
            chk("cont.both_done", W'(done0 & done1), '0);
            if (gnt0 || gnt1) begin
                chk("cont.gnt_order", W'(gnt1), W'(exp_next1));
                chk("cont.done_before_gnt", W'(pending), '0);
                exp_next1 = ~exp_next1;
                pending = 1'b1;
                ngnt++;
            end
            if (done0 || done1) pending = 1'b0;
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        chk("cont.gnt_count", W'(ngnt), 32'd4);
        @(negedge clock);
        chk_outs("cont.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        // Withdrawn request: req0 pulses only while requester 1 is in ISSUE.
        set_req(1, 1'b1, 1'b0, 32'h20, '0);
        @(negedge clock);
        chk("wd.gnt1", W'(gnt1), 32'd1);
        set_req(1, 1'b0, 1'b0, '0, '0);
        set_req(0, 1'b1, 1'b1, 32'h44, 32'h5555_5555);
        @(negedge clock);
        set_req(0, 1'b0, 1'b0, '0, '0);
        nbad0 = 0;
        ndone1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (gnt0 || done0) nbad0++;
            if (done1) ndone1++;
        end
        exp_rd[1] = 32'h1234_5678;
        chk("wd.no_gnt0_done0", W'(nbad0), '0);
        chk("wd.done1_count", W'(ndone1), 32'd1);
        chk_outs("wd.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        // Leave the pointer at 1, then abort a read in WAIT.
        v = '{0, 1'b1, 32'h48, 32'h0BAD_CAFE, 32'h0};
        do_access("ptr_set", v);
        set_req(1, 1'b1, 1'b0, 32'h20, '0);
        @(negedge clock);
        chk("abort.gnt1", W'(gnt1), 32'd1);
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(negedge clock);
        chk("abort.in_wait_addr", mem_addr, 32'h20);
        reset_n = 1'b0;
        #1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        chk_outs("abort.now", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk_outs("abort.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        end
        set_req(0, 1'b1, 1'b1, 32'h50, 32'h1);
        set_req(1, 1'b1, 1'b1, 32'h54, 32'h2);
        @(negedge clock);
        chk("abort.ptr_gnt0", W'(gnt0), 32'd1);
        chk("abort.ptr_gnt1", W'(gnt1), 32'd0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clock);
        chk_outs("final.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates and sequences the single data-memory port between two requesters: requester 0 is the CPU load/store path and requester 1 is the secondary loader.
- Round-robin arbitration with a request/grant/done handshake.
- Drives the memory enable, write-enable, address and write-data lines that the load path currently drives directly.
- Returns read data to the winning requester after a fixed, parameterised memory latency.

Parameters:
- WIDTH, 32, width of address, write data and read data.
- RD_LATENCY, 1, cycles from the memory-enable cycle to the mem_rdata capture edge; legal range 1..4.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0 write (1) / read (0).
- addr0  in  WIDTH  requester 0 address.
- wdata0  in  WIDTH  requester 0 write data.
- gnt0  out  1  requester 0 grant pulse.
- done0  out  1  requester 0 completion pulse.
- rdata0  out  WIDTH  requester 0 read data.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1: same as above, for requester 1.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_ena  out  1  memory access enable.
- mem_wr_ena  out  1  memory write enable.
- mem_rdata  in  WIDTH  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - FSM goes to IDLE; round-robin pointer = 0.
  - All outputs go to 0 immediately, including rdata0/rdata1 and the latched request registers.
  - A reset mid-access aborts the access: no done pulse, memory lines go to 0.
- No tri-state outputs. All outputs are registered and always driven; idle value is 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req0/req1 are sampled only in this state.
  - One request: that requester wins.
  - Both requests: the pointer selects the winner (0 = requester 0).
  - On the edge: latch winner id, we, addr, wdata; go to ISSUE. The winner's gnt is high for exactly the ISSUE cycle.
  - Neither request: stay in IDLE.
  - A req deasserted before being sampled in IDLE is ignored.
- ISSUE (1 cycle):
  - mem_ena=1; mem_wr_ena=latched we; mem_addr and mem_wdata = latched values.
  - Write: next state is DONE.
  - Read: next state is WAIT, latency counter loaded with RD_LATENCY.
- WAIT:
  - mem_ena=0, mem_wr_ena=0; mem_addr held at the latched address.
  - Counter decrements each cycle.
  - On the edge where the counter reaches 1: capture mem_rdata into the winner's rdata register; go to DONE.
  - Number of WAIT cycles = RD_LATENCY.
- DONE (1 cycle):
  - Winner's done is high. Its rdata is valid from this cycle and holds until that requester's next read completes; writes never modify rdata.
  - Pointer is set to the non-winner.
  - Next state is IDLE.
  - mem_addr/mem_wdata return to 0 from DONE onward.
- Latency:
  - Write: req sampled at edge k → gnt in cycle k+1 → done in cycle k+2.
  - Read: done in cycle k+2+RD_LATENCY.
  - IDLE occupies at least one cycle between accesses.
- Handshake rules:
  - A requester holds req, we, addr and wdata stable until gnt.
  - Values after gnt are don't-care.
  - req still high when the FSM is next in IDLE is a new request.
- Simultaneous events:
  - gnt0 and gnt1 are never both high; the same holds for done0/done1.
  - Continuous requests from both sides alternate strictly 0,1,0,1,…
- Address and data pass through unmodified; no alignment or range checks.

Test Plan:
- Reset/idle: hold reset_n=0, then release with no requests → all outputs 0 and busy=0 for 10 cycles.
- Single write: req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF → gnt0 in cycle k+1, with mem_ena=1, mem_wr_ena=1, mem_addr=0x10, mem_wdata=0xDEADBEEF → done0 in cycle k+2, rdata0 unchanged.
- Single read, RD_LATENCY=2: req1 read addr1=0x20, memory model returns 0x12345678 → gnt1 at k+1, mem_ena high 1 cycle, mem_wr_ena=0 → done1 at k+4, rdata1=0x12345678 held afterwards.
- Contention: req0 and req1 asserted together from reset and kept high → grants in order 0,1,0,1; never simultaneous; each done precedes the next gnt.
- Abort: assert reset_n=0 during WAIT of a read → mem_ena, busy, rdata and done drop to 0 immediately; after release, no done pulse and pointer = 0.
- Withdrawn request: req0 high for 1 cycle while the FSM is in ISSUE for requester 1 and low again before IDLE → no gnt0 and no done0 ever issued.
